led_pwm_driver: RTL

//  Downstream consumer of the 8-bit LED PIO out_port. Converts each on/off request bit into a
//  PWM-dimmed, optionally soft-faded drive signal for the board LED pins. Updates apply only
//  at PWM period boundaries, so pins never glitch. Sits between the PIO and the top-level LED pads.

---
 rtl/led_pwm_driver_pkg.sv | 27 ++
 rtl/led_pwm_driver_if.sv | 22 ++
 rtl/led_pwm_driver_channel.sv | 51 +++++
 rtl/led_pwm_driver.sv | 105 ++++++++++
 4 files changed

// File: rtl/led_pwm_driver_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | led_drv_pkg: shared defaults and saturating fade-step helper         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package led_drv_pkg;

  localparam int unsigned DEF_PWM_BITS = 8;
  localparam int unsigned DEF_PRESCALE = 50;

  // Moves level by inc toward target, landing exactly on target instead of overshooting.
  function automatic int unsigned sat_step(input int unsigned level,
                                           input int unsigned target,
                                           input int unsigned inc);
    int unsigned nxt;
    nxt = target;
    if (level < target) begin
      if ((target - level) > inc) nxt = level + inc;
    end else if (level > target) begin
      if ((level - target) > inc) nxt = level - inc;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_driver_if: PIO request side and LED pad side of the driver   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface led_pwm_driver_if #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned PWM_BITS = 8
);
  logic [NUM_LEDS-1:0] led_req;
  logic [PWM_BITS-1:0] brightness;
  logic [NUM_LEDS-1:0] led_pins;
  logic                period_end;
  logic                fade_busy;

  modport master (output led_req, brightness,
                  input  led_pins, period_end, fade_busy);
  modport slave  (input  led_req, brightness,
                  output led_pins, period_end, fade_busy);
endinterface
`default_nettype wire

// File: rtl/led_pwm_driver_channel.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_channel: one LED level register and its PWM comparator       |
// | Optional feature macro: LED_FADE_EN (ramped level steps)             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_pwm_channel
  import led_drv_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned FADE_INC = 8
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  input  wire logic [PWM_BITS-1:0] target_i,
  input  wire logic                step_i,
  input  wire logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                     pin_o,
  output logic                     busy_o
);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic                pin_q;

  always_comb begin
    level_d = level_q;
    if (step_i) begin
`ifdef LED_FADE_EN
      level_d = PWM_BITS'(sat_step(32'(level_q), 32'(target_i), FADE_INC));
`else
      level_d = target_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      pin_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      pin_q   <= (pwm_cnt_i < level_q);
    end
  end

  assign pin_o  = pin_q;
  assign busy_o = (level_q != target_i);

endmodule
`default_nettype wire

// File: rtl/led_pwm_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_driver: PIO on/off bits to glitch-free PWM-dimmed LED pins   |
// | Optional feature macro: LED_FADE_EN (soft fade between levels)       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_pwm_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned PWM_BITS     = DEF_PWM_BITS,
  parameter int unsigned PRESCALE     = DEF_PRESCALE,
  parameter int unsigned FADE_INC     = 8,
  parameter int unsigned FADE_PERIODS = 2
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  led_pwm_driver_if.slave bus
);

  localparam int unsigned          c_PRESC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(PRESCALE - 1);

  logic [c_PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_BITS-1:0]  pwm_q, pwm_d;
  logic [NUM_LEDS-1:0]  req_q, req_d;
  logic [PWM_BITS-1:0]  bright_q, bright_d;
  logic                 busy_q, busy_d;
  logic                 w_tick, w_period_end, w_step;
  logic [NUM_LEDS-1:0]  w_pins, w_busy;

  assign w_tick       = (presc_q == c_PRESC_MAX);
  assign w_period_end = w_tick && (pwm_q == '1);

`ifdef LED_FADE_EN
  localparam int unsigned          c_FADE_W   = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam logic [c_FADE_W-1:0]  c_FADE_MAX = c_FADE_W'(FADE_PERIODS - 1);

  logic [c_FADE_W-1:0] fade_q, fade_d;

  always_comb begin
    fade_d = fade_q;
    if (w_period_end) fade_d = (fade_q == c_FADE_MAX) ? '0 : fade_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fade_q <= '0;
    else          fade_q <= fade_d;
  end

  assign w_step = w_period_end && (fade_q == c_FADE_MAX);
`else
  assign w_step = w_period_end;
`endif

  // Inputs are sampled only at the period boundary so a level never changes mid-period.
  always_comb begin
    presc_d  = w_tick ? '0 : presc_q + 1'b1;
    pwm_d    = w_tick ? pwm_q + 1'b1 : pwm_q;
    req_d    = w_period_end ? bus.led_req    : req_q;
    bright_d = w_period_end ? bus.brightness : bright_q;
    busy_d   = |w_busy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      pwm_q    <= '0;
      req_q    <= '0;
      bright_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      pwm_q    <= pwm_d;
      req_q    <= req_d;
      bright_q <= bright_d;
      busy_q   <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
    logic [PWM_BITS-1:0] w_target;
    assign w_target = req_q[g] ? bright_q : '0;

    led_pwm_channel #(
      .PWM_BITS (PWM_BITS),
      .FADE_INC (FADE_INC)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .target_i  (w_target),
      .step_i    (w_step),
      .pwm_cnt_i (pwm_q),
      .pin_o     (w_pins[g]),
      .busy_o    (w_busy[g])
    );
  end

  assign bus.led_pins   = w_pins;
  assign bus.period_end = w_period_end;
  assign bus.fade_busy  = busy_q;

endmodule
`default_nettype wire
